// File: rtl/attn_sequencer_if.sv
// Request/score handshake bundle between the attention sequencer and the Q/KV memories
// and the dot-product score stage.
interface attn_sequencer_if #(
    parameter int SEQ_LEN = 64
) ();
    logic                       q_req_vld;
    logic [$clog2(SEQ_LEN)-1:0] q_req_addr;
    logic                       q_req_rdy;
    logic                       kv_req_vld;
    logic [$clog2(SEQ_LEN)-1:0] kv_req_addr;
    logic                       kv_req_rdy;
    logic                       score_vld;
    logic                       score_rdy;

    modport master (
        output q_req_vld, q_req_addr, kv_req_vld, kv_req_addr,
        input  q_req_rdy, kv_req_rdy, score_vld, score_rdy
    );

    modport slave (
        input  q_req_vld, q_req_addr, kv_req_vld, kv_req_addr,
        output q_req_rdy, kv_req_rdy, score_vld, score_rdy
    );
endinterface

// File: rtl/attn_sequencer.sv
// Attention pass sequencer: per query row issues one Q read, then SEQ_LEN credit-limited K/V reads.
// Optional KV stall counter enabled by defining ATTN_SEQ_PERF_EN.
module attn_sequencer #(
    parameter int SEQ_LEN = 64,
    parameter int CREDITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [$clog2(SEQ_LEN):0]   i_num_rows,
    attn_sequencer_if.master           bus,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic [$clog2(SEQ_LEN)-1:0] o_row_idx,
    output logic [31:0]                o_stall_cycles
);
    localparam int AW = $clog2(SEQ_LEN);

    typedef enum logic [2:0] {IDLE, ISSUE_Q, ISSUE_KV, DRAIN, DONE} state_t;

    state_t        r_state;
    logic          r_q_vld;
    logic          r_kv_vld;
    logic [AW-1:0] r_row;
    logic [AW-1:0] r_key;
    logic [AW:0]   r_num_rows;
    logic [3:0]    r_out;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_q_hs;
    logic          w_kv_hs;
    logic          w_score_hs;
    logic          w_err_set;
    logic [3:0]    w_out_nxt;
    logic          w_kv_room;
    logic [AW:0]   w_row_inc;

    assign w_q_hs     = r_q_vld && bus.q_req_rdy;
    assign w_kv_hs    = r_kv_vld && bus.kv_req_rdy;
    assign w_score_hs = bus.score_vld && bus.score_rdy;
    assign w_err_set  = w_score_hs && (r_out == '0);
    assign w_row_inc  = {1'b0, r_row} + (AW+1)'(1);

    // kv valid is registered, so it is computed from next-cycle outstanding count
    always_comb begin
        w_out_nxt = r_out;
        if (w_kv_hs && !w_score_hs)
            w_out_nxt = r_out + 4'd1;
        else if (!w_kv_hs && w_score_hs && r_out != '0)
            w_out_nxt = r_out - 4'd1;
    end

    assign w_kv_room = (w_out_nxt < 4'(CREDITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_q_vld    <= 1'b0;
            r_kv_vld   <= 1'b0;
            r_row      <= '0;
            r_key      <= '0;
            r_num_rows <= '0;
            r_out      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_out  <= w_out_nxt;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_err      <= 1'b0;
                        r_num_rows <= i_num_rows;
                        r_row      <= '0;
                        r_busy     <= 1'b1;
                        if (i_num_rows != '0) begin
                            r_state <= ISSUE_Q;
                            r_q_vld <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ISSUE_Q: begin
                    if (w_q_hs) begin
                        r_q_vld  <= 1'b0;
                        r_key    <= '0;
                        r_state  <= ISSUE_KV;
                        r_kv_vld <= w_kv_room;
                    end
                end
                ISSUE_KV: begin
                    if (w_kv_hs && r_key == '1) begin
                        r_state  <= DRAIN;
                        r_kv_vld <= 1'b0;
                    end else begin
                        if (w_kv_hs)
                            r_key <= r_key + AW'(1);
                        r_kv_vld <= w_kv_room;
                    end
                end
                DRAIN: begin
                    if (r_out == '0) begin
                        if (w_row_inc < r_num_rows) begin
                            r_row   <= w_row_inc[AW-1:0];
                            r_state <= ISSUE_Q;
                            r_q_vld <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
            // a stray score sets err even in the cycle a start clears it
            if (w_err_set)
                r_err <= 1'b1;
        end
    end

`ifdef ATTN_SEQ_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall <= '0;
        else if (r_state == IDLE && i_start)
            r_stall <= '0;
        else if (r_state == ISSUE_KV && !w_kv_hs && r_stall != '1)
            r_stall <= r_stall + 32'd1;
    end

    assign o_stall_cycles = r_stall;
`else
    assign o_stall_cycles = '0;
`endif

    assign bus.q_req_vld   = r_q_vld;
    assign bus.q_req_addr  = r_row;
    assign bus.kv_req_vld  = r_kv_vld;
    assign bus.kv_req_addr = r_key;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_row_idx       = r_row;
endmodule

// File: doc/attn_sequencer.md
ATTN_SEQUENCER -- requirements
Module: attn_sequencer

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 64, keys per query row (power of two, >=2).
REQ-002 SHALL have parameter CREDITS, default 4, max KV requests issued but not yet scored (1..15).
REQ-003 SHALL have ports clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  in  1  pulse starting a pass, sampled only in IDLE.
REQ-005 SHALL have port num_rows  in  $clog2(SEQ_LEN)+1  query rows for the pass, latched on accepted start.
REQ-006 SHALL have ports q_req_vld  out  1; q_req_addr  out  $clog2(SEQ_LEN)  Q-row read request; q_req_rdy  in  1.
REQ-007 SHALL have ports kv_req_vld  out  1; kv_req_addr  out  $clog2(SEQ_LEN)  shared K/V read request; kv_req_rdy  in  1.
REQ-008 SHALL have ports score_vld  in  1; score_rdy  in  1  observed score handshake at dot-product output.
REQ-009 SHALL have ports busy  out  1; done  out  1  one-cycle pulse; err  out  1  sticky; row_idx  out  $clog2(SEQ_LEN)  current row.
REQ-010 SHALL have port stall_cycles  out  32  KV stall counter (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE_Q, ISSUE_KV, DRAIN, DONE.
REQ-012 IDLE: start=1 and num_rows!=0 -> ISSUE_Q next cycle; start=1 and num_rows=0 -> DONE; start ignored in all other states.
REQ-013 ISSUE_Q: q_req_vld=1, q_req_addr=row_idx; on q_req_vld&&q_req_rdy -> ISSUE_KV with key counter=0.
REQ-014 ISSUE_KV: kv_req_vld=1 iff outstanding<CREDITS; kv_req_addr=key counter; each kv handshake increments key counter and outstanding.
REQ-015 Handshake on key SEQ_LEN-1 -> DRAIN; key counter SHALL not wrap within a row.
REQ-016 outstanding SHALL decrement on score_vld&&score_rdy; simultaneous issue and score in one cycle leaves it unchanged.
REQ-017 DRAIN: when outstanding=0 -> ISSUE_Q with row_idx+1 if row_idx+1<num_rows, else DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-019 Score handshake while outstanding=0 SHALL set err (sticky until rst or accepted start) and leave outstanding at 0.
REQ-020 q_req_vld and kv_req_vld SHALL never be asserted in the same cycle; once asserted, address SHALL be stable until handshake.
REQ-021 All outputs SHALL be registered or decoded from registered state only; no combinational path from *_rdy or score_* to *_vld.

Reset
REQ-022 On rst: state IDLE; q_req_vld, kv_req_vld, busy, done, err = 0; row_idx, key counter, outstanding, stall_cycles = 0.
REQ-023 rst asserted mid-pass SHALL abandon the pass with no done pulse; next start begins a fresh pass.

Configuration
REQ-024 With ATTN_SEQ_PERF_EN defined, stall_cycles SHALL count ISSUE_KV cycles where no kv handshake occurs (credit-blocked or kv_req_rdy=0), saturating at 2^32-1, cleared on accepted start.
REQ-025 Without ATTN_SEQ_PERF_EN, stall_cycles SHALL be tied to 0 and no counter logic instantiated.

Verification
REQ-026 start, num_rows=1, all rdy=1, score returned 1 cycle after each kv handshake -> q addr 0, kv addrs 0..63 in order, done pulse once, err=0.
REQ-027 num_rows=3, CREDITS=4, scores withheld -> exactly 4 kv handshakes then kv_req_vld=0; release one score -> one more kv issued next cycle.
REQ-028 start with num_rows=0 -> done pulse 1 cycle after IDLE exit, no q or kv requests, busy high for exactly 1 cycle.
REQ-029 score handshake injected in IDLE -> err=1, outstanding stays 0; next accepted start clears err.
REQ-030 rst asserted during ISSUE_KV of row 1 -> all outputs 0 next cycle, no done; new start with num_rows=2 completes with q addrs 0,1.
REQ-031 ATTN_SEQ_PERF_EN defined, kv_req_rdy held 0 for 10 cycles in ISSUE_KV -> stall_cycles=10; undefined -> stall_cycles=0.
